// File: rtl/hcsr04_echo_emulator.sv
// rtl/hcsr04_echo_emulator.sv - HC-SR04 ultrasonic sensor emulator (trig in, echo out); optional jitter via ECHO_JITTER_EN
module hcsr04_echo_emulator #(
    parameter int unsigned CLK_FREQ_HZ   = 50000000,
    parameter int unsigned TRIG_MIN_US   = 10,
    parameter int unsigned ECHO_DELAY_US = 450,
    parameter int unsigned US_PER_CM     = 58,
    parameter int unsigned MAX_CM        = 400,
    parameter int unsigned NO_ECHO_US    = 38000,
    parameter int unsigned HOLDOFF_US    = 10000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        trig,
    input  logic [9:0]  dist_cm,
    output logic        echo,
    output logic        busy,
    output logic        trig_err,
    output logic [15:0] meas_count
);

    localparam int unsigned CYC_PER_US = CLK_FREQ_HZ / 1000000;
    localparam int unsigned TRIG_CYC   = TRIG_MIN_US * CYC_PER_US;
    localparam int unsigned DLY_CYC    = ECHO_DELAY_US * CYC_PER_US;
    localparam int unsigned HOLD_CYC   = HOLDOFF_US * CYC_PER_US;
    localparam int unsigned NOECHO_CYC = NO_ECHO_US * CYC_PER_US;
    // Longest in-range echo, including the largest possible jitter of 7 us
    localparam int unsigned MAXW_CYC   = (MAX_CM * US_PER_CM + 7) * CYC_PER_US;
    localparam int unsigned M_A = (NOECHO_CYC > MAXW_CYC) ? NOECHO_CYC : MAXW_CYC;
    localparam int unsigned M_B = (M_A > DLY_CYC) ? M_A : DLY_CYC;
    localparam int unsigned M_C = (M_B > HOLD_CYC) ? M_B : HOLD_CYC;
    localparam int unsigned M_D = (M_C > TRIG_CYC) ? M_C : TRIG_CYC;
    localparam int unsigned CNT_W = $clog2(M_D + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG_HIGH = 3'd1;
    localparam logic [2:0] S_DELAY     = 3'd2;
    localparam logic [2:0] S_ECHO      = 3'd3;
    localparam logic [2:0] S_HOLDOFF   = 3'd4;

    logic             sync1_q;
    logic             trig_s_q;
    logic             trig_prev_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             echo_q;
    logic             busy_q;
    logic             trig_err_q, trig_err_d;
    logic [15:0]      meas_q;
    logic             accept;
    logic [31:0]      w_us;
    logic             rise, fall;

`ifdef ECHO_JITTER_EN
    logic [15:0]      lfsr_q;
`endif

    assign rise = trig_s_q & ~trig_prev_q;
    assign fall = ~trig_s_q & trig_prev_q;

    // Echo width in microseconds for the distance currently presented
    always_comb begin
        w_us = NO_ECHO_US;
        if (dist_cm != 10'd0 && 32'(dist_cm) <= MAX_CM) begin
`ifdef ECHO_JITTER_EN
            w_us = 32'(dist_cm) * US_PER_CM + 32'(lfsr_q[2:0]);
`else
            w_us = 32'(dist_cm) * US_PER_CM;
`endif
        end
    end

    // Next-state logic; enable low aborts everything back to IDLE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        trig_err_d = 1'b0;
        accept     = 1'b0;
        if (!enable) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            target_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_d = S_TRIG_HIGH;
                        cnt_d   = '0;
                    end
                end
                S_TRIG_HIGH: begin
                    if (fall) begin
                        cnt_d = '0;
                        if (cnt_q >= CNT_W'(TRIG_CYC)) begin
                            state_d  = S_DELAY;
                            target_d = CNT_W'(w_us * CYC_PER_US);
                            accept   = 1'b1;
                        end else begin
                            state_d    = S_IDLE;
                            trig_err_d = 1'b1;
                        end
                    end else if (cnt_q < CNT_W'(TRIG_CYC)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DELAY: begin
                    if (cnt_q == CNT_W'(DLY_CYC - 1)) begin
                        state_d = S_ECHO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ECHO: begin
                    if (cnt_q == target_q - 1'b1) begin
                        state_d = S_HOLDOFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Trig synchroniser plus the previous-value flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            sync1_q     <= trig;
            trig_s_q    <= sync1_q;
            trig_prev_q <= trig_s_q;
        end
    end

    // State, counters and registered outputs (echo/busy follow the state one cycle later)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            target_q   <= '0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            trig_err_q <= 1'b0;
            meas_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            trig_err_q <= trig_err_d;
            echo_q     <= enable && (state_q == S_ECHO);
            busy_q     <= enable && (state_q == S_DELAY || state_q == S_ECHO ||
                                     state_q == S_HOLDOFF);
            if (echo_q && state_q == S_HOLDOFF) begin
                meas_q <= meas_q + 16'd1;
            end
        end
    end

`ifdef ECHO_JITTER_EN
    // Jitter source: Fibonacci LFSR x^16+x^14+x^13+x^11, stepped after each accepted trigger
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else if (accept) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`endif

    assign echo       = echo_q;
    assign busy       = busy_q;
    assign trig_err   = trig_err_q;
    assign meas_count = meas_q;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// tb/tb_hcsr04_echo_emulator.sv - scoreboard bench for hcsr04_echo_emulator with time-scaled parameters
module tb_hcsr04_echo_emulator;

    localparam int unsigned CLK_HZ  = 2000000;
    localparam int unsigned CYC     = 2;
    localparam int unsigned TMIN_US = 10;
    localparam int unsigned DLY_US  = 45;
    localparam int unsigned UPC     = 3;
    localparam int unsigned MAXCM   = 400;
    localparam int unsigned NOE_US  = 1500;
    localparam int unsigned HOLD_US = 200;
    localparam int LAT      = 3 + DLY_US * CYC;
    localparam int HOLD_CYC = HOLD_US * CYC;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        trig;
    logic [9:0]  dist_cm;
    logic        echo;
    logic        busy;
    logic        trig_err;
    logic [15:0] meas_count;

    hcsr04_echo_emulator #(
        .CLK_FREQ_HZ(CLK_HZ), .TRIG_MIN_US(TMIN_US), .ECHO_DELAY_US(DLY_US),
        .US_PER_CM(UPC), .MAX_CM(MAXCM), .NO_ECHO_US(NOE_US), .HOLDOFF_US(HOLD_US)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .trig(trig),
        .dist_cm(dist_cm), .echo(echo), .busy(busy), .trig_err(trig_err),
        .meas_count(meas_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fall;
        int width;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    bit          cur_valid = 0;
    bit          mon_abort = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          rise_cyc = 0;
    int          echo_fall_cyc = 0;
    int          busy_fall_cyc = 0;
    int          err_cnt = 0;
    int          err_long = 0;
    bit          busy_seen = 0;
    bit          echo_prev = 0;
    bit          busy_prev = 0;
    bit          err_prev = 0;
    logic [15:0] lfsr_m = 16'hACE1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_w(input int d);
        if (d >= 1 && d <= int'(MAXCM)) begin
`ifdef ECHO_JITTER_EN
            return (d * int'(UPC) + int'(lfsr_m[2:0])) * int'(CYC);
`else
            return d * int'(UPC) * int'(CYC);
`endif
        end
        return int'(NOE_US) * int'(CYC);
    endfunction

    // Output monitor: pops the scoreboard on each echo rise, checks latency and width
    always @(negedge clk) begin
        if (echo && !echo_prev) begin
            rise_cyc = cyc;
            if (sb.size() == 0) begin
                check_eq("unexpected_echo", 1, 0);
                cur_valid = 0;
            end else begin
                cur = sb.pop_front();
                cur_valid = 1;
                check_eq("echo_latency", cyc - cur.fall, LAT);
            end
        end
        if (!echo && echo_prev) begin
            echo_fall_cyc = cyc;
            if (mon_abort) mon_abort = 0;
            else if (cur_valid) check_eq("echo_width", cyc - rise_cyc, cur.width);
            cur_valid = 0;
        end
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        if (busy) busy_seen = 1;
        if (trig_err) begin
            err_cnt++;
            if (err_prev) err_long++;
        end
        echo_prev = echo;
        busy_prev = busy;
        err_prev  = trig_err;
    end

    task automatic pulse(input int hi, input int d, input bit accepted, input bit expect_echo);
        exp_t e;
        @(negedge clk);
        dist_cm = 10'(d);
        trig = 1'b1;
        repeat (hi) @(negedge clk);
        trig = 1'b0;
        if (expect_echo) begin
            e.fall  = cyc + 1;
            e.width = exp_w(d);
            sb.push_back(e);
        end
        if (accepted) lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        repeat (4) @(negedge clk);
        dist_cm = 10'(d) ^ 10'h155;
    endtask

    task automatic wait_quiet(input int budget);
        int q = 0;
        int n = 0;
        while (q < 8 && n < budget) begin
            @(negedge clk);
            n++;
            if (!busy && !echo) q++;
            else q = 0;
        end
        check_eq("quiet_reached", int'(q >= 8), 1);
    endtask

    task automatic wait_echo(input bit level, input int budget);
        int n = 0;
        while (echo !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("echo_level_reached", int'(echo), int'(level));
    endtask

    initial begin
        int m0;
        int e0;
        reset_n = 1'b0;
        enable  = 1'b1;
        trig    = 1'b0;
        dist_cm = 10'd0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_echo", int'(echo), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_trig_err", int'(trig_err), 0);
        check_eq("rst_meas", int'(meas_count), 0);

        // Reset asserted mid-echo drops echo without waiting for a clock
        pulse(40, 100, 1, 1);
        wait_echo(1'b1, 400);
        repeat (100) @(negedge clk);
        mon_abort = 1;
        #2 reset_n = 1'b0;
        lfsr_m = 16'hACE1;
        #1 check_eq("async_echo_drop", int'(echo), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_echo", int'(echo), 0);
        check_eq("post_rst_busy", int'(busy), 0);
        check_eq("post_rst_meas", int'(meas_count), 0);

        // Nominal pulse and busy duration after echo fall
        pulse(40, 100, 1, 1);
        wait_quiet(3000);
        check_eq("nominal_meas", int'(meas_count), 1);
        check_eq("holdoff_len", busy_fall_cyc - echo_fall_cyc, HOLD_CYC);

        // Short trigger is rejected with a single-cycle error
        e0 = err_cnt;
        busy_seen = 0;
        pulse(10, 100, 0, 0);
        repeat (60) @(negedge clk);
        check_eq("short_err_count", err_cnt - e0, 1);
        check_eq("short_err_width", err_long, 0);
        check_eq("short_busy", int'(busy_seen), 0);

        // Range boundaries and out-of-range targets
        pulse(40, 0, 1, 1);    wait_quiet(5000);
        pulse(40, 401, 1, 1);  wait_quiet(5000);
        pulse(40, 400, 1, 1);  wait_quiet(5000);
        pulse(40, 1, 1, 1);    wait_quiet(5000);
        pulse(40, 57, 1, 1);   wait_quiet(5000);
        check_eq("range_meas", int'(meas_count), 6);

        // Triggers during ECHO and HOLDOFF are ignored
        e0 = err_cnt;
        pulse(40, 50, 1, 1);
        wait_echo(1'b1, 400);
        repeat (20) @(negedge clk);
        pulse(40, 80, 0, 0);
        wait_echo(1'b0, 1000);
        repeat (50) @(negedge clk);
        pulse(40, 80, 0, 0);
        wait_quiet(3000);
        check_eq("busy_ignore_meas", int'(meas_count), 7);

        // Trig raised in HOLDOFF and still high on return to IDLE is not accepted
        pulse(40, 20, 1, 1);
        wait_echo(1'b1, 400);
        wait_echo(1'b0, 1000);
        repeat (100) @(negedge clk);
        trig = 1'b1;
        repeat (500) @(negedge clk);
        trig = 1'b0;
        repeat (200) @(negedge clk);
        wait_quiet(3000);
        check_eq("held_trig_meas", int'(meas_count), 8);
        check_eq("ignored_trig_err", err_cnt - e0, 0);

        // Enable low in DELAY aborts the pulse
        m0 = int'(meas_count);
        pulse(40, 100, 1, 0);
        repeat (30) @(negedge clk);
        check_eq("busy_in_delay", int'(busy), 1);
        enable = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_echo", int'(echo), 0);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (300) @(negedge clk);
        check_eq("abort_meas", int'(meas_count), m0);

        // Accepted again after the abort (exercises LFSR step count when jitter is built in)
        pulse(40, 10, 1, 1);
        wait_quiet(3000);
        pulse(40, 10, 1, 1);
        wait_quiet(3000);
        check_eq("final_meas", int'(meas_count), m0 + 2);
        check_eq("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
